// File: rtl/frame_pkg.sv
// Shared types and constants for the frame-buffer pixel reader.
package frame_pkg;

  localparam int PIX_W        = 4;
  localparam int WORD_W       = 16;
  localparam int PIX_PER_WORD = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } frame_rd_state_t;

endpackage

// File: rtl/word_fifo.sv
// Small synchronous show-ahead FIFO holding prefetched SRAM words.
// rdata_o always presents the oldest entry; pop consumes it.
module word_fifo
  import frame_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             push_ok;
  logic             pop_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign push_ok = push_i && (count_q != CNT_W'(DEPTH));
  assign pop_ok  = pop_i && (count_q != '0);

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop_ok)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/frame_reader.sv
// Fetches one frame of packed 4-bit pixels from SRAM and streams them out
// in raster order with a ready/stall handshake and frame/line markers.
module frame_reader
  import frame_pkg::*;
#(
  parameter int IMG_W      = 640,
  parameter int IMG_H      = 480,
  parameter int ADDR_W     = 18,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              mem_rd_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rd_gnt,
  input  logic              mem_rd_valid,
  input  logic [WORD_W-1:0] mem_rd_data,
  output logic [PIX_W-1:0]  pixel_out,
  output logic              out_ready,
  input  logic              out_stall,
  output logic              sof,
  output logic              eol,
  output logic              eof,
  output logic              busy,
  output logic              done
);

  localparam int TOTAL_WORDS = IMG_W * IMG_H / PIX_PER_WORD;
  localparam int WC_W        = $clog2(TOTAL_WORDS) + 1;
  localparam int CNT_W       = $clog2(FIFO_DEPTH + 1);
  localparam int COL_W       = $clog2(IMG_W);
  localparam int ROW_W       = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int PIDX_W      = $clog2(PIX_PER_WORD);

  frame_rd_state_t   state_q, state_d;
  logic [ADDR_W-1:0] base_q;
  logic [WC_W-1:0]   req_cnt_q, req_cnt_d;
  logic [CNT_W-1:0]  outst_q, outst_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [PIDX_W-1:0] pidx_q, pidx_d;
  logic              uvld_q, uvld_d;
  logic [WORD_W-1:0] word_q;
  logic              done_q;

  logic [CNT_W-1:0]  fifo_cnt;
  logic [WORD_W-1:0] fifo_rdata;
  logic [CNT_W:0]    inflight;
  logic              credit_ok;
  logic              rd_fire;
  logic              push;
  logic              pop;
  logic              xfer;
  logic              last_pix;
  logic              unpack_free;
  logic              at_eol;
  logic              at_last_row;
  logic              frame_end;

  // Words granted but not returned plus words parked in the FIFO must stay
  // below the FIFO depth, so a return can never find the FIFO full.
  assign inflight    = {1'b0, outst_q} + {1'b0, fifo_cnt};
  assign credit_ok   = inflight < (CNT_W + 1)'(FIFO_DEPTH);

  assign rd_fire     = mem_rd_req && mem_rd_gnt;
  assign push        = (state_q == RUN) && mem_rd_valid;
  assign xfer        = uvld_q && !out_stall;
  assign last_pix    = (pidx_q == PIDX_W'(PIX_PER_WORD - 1));
  assign unpack_free = !uvld_q || (xfer && last_pix);
  assign pop         = (state_q == RUN) && (fifo_cnt != '0) && unpack_free;
  assign at_eol      = (col_q == COL_W'(IMG_W - 1));
  assign at_last_row = (row_q == ROW_W'(IMG_H - 1));
  assign frame_end   = xfer && at_eol && at_last_row;

  word_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (mem_rd_data),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .count_o (fifo_cnt)
  );

  // FSM state register plus all control counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      req_cnt_q <= '0;
      outst_q   <= '0;
      col_q     <= '0;
      row_q     <= '0;
      pidx_q    <= '0;
      uvld_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_cnt_q <= req_cnt_d;
      outst_q   <= outst_d;
      col_q     <= col_d;
      row_q     <= row_d;
      pidx_q    <= pidx_d;
      uvld_q    <= uvld_d;
      done_q    <= frame_end;
    end
  end

  // Frame base is captured when a frame is accepted.
  always_ff @(posedge clk) begin
    if ((state_q == IDLE) && start) base_q <= base_addr;
  end

  // Unpacker word register, loaded from the FIFO head.
  always_ff @(posedge clk) begin
    if (pop) word_q <= fifo_rdata;
  end

  // Next-state logic: a frame runs from start until the eof pixel transfers.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (frame_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: busy flag and credit-limited read request.
  always_comb begin
    busy       = 1'b0;
    mem_rd_req = 1'b0;
    case (state_q)
      RUN: begin
        busy       = 1'b1;
        mem_rd_req = (req_cnt_q < WC_W'(TOTAL_WORDS)) && credit_ok;
      end
      default: ;
    endcase
  end

  // Counter, credit, unpacker and raster next-state; everything clears
  // outside a frame and on the cycle the frame finishes.
  always_comb begin
    req_cnt_d = req_cnt_q;
    outst_d   = outst_q;
    col_d     = col_q;
    row_d     = row_q;
    pidx_d    = pidx_q;
    uvld_d    = uvld_q;
    if (state_q == RUN) begin
      if (rd_fire) req_cnt_d = req_cnt_q + 1'b1;
      outst_d = outst_q + CNT_W'(rd_fire) - CNT_W'(push);
      if (pop) begin
        uvld_d = 1'b1;
        pidx_d = '0;
      end else if (xfer) begin
        if (last_pix) uvld_d = 1'b0;
        else          pidx_d = pidx_q + 1'b1;
      end
      if (xfer) begin
        if (at_eol) begin
          col_d = '0;
          row_d = row_q + 1'b1;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      if (frame_end) begin
        req_cnt_d = '0;
        outst_d   = '0;
        col_d     = '0;
        row_d     = '0;
        pidx_d    = '0;
        uvld_d    = 1'b0;
      end
    end else begin
      req_cnt_d = '0;
      outst_d   = '0;
      col_d     = '0;
      row_d     = '0;
      pidx_d    = '0;
      uvld_d    = 1'b0;
    end
  end

  assign mem_addr  = mem_rd_req ? (base_q + ADDR_W'(req_cnt_q)) : '0;
  assign out_ready = uvld_q;
  assign pixel_out = uvld_q ? word_q[PIX_W*pidx_q +: PIX_W] : '0;
  assign sof       = uvld_q && (col_q == '0) && (row_q == '0);
  assign eol       = uvld_q && at_eol;
  assign eof       = uvld_q && at_eol && at_last_row;
  assign done      = done_q;

endmodule

// File: tb/tb_frame_reader.sv
// Directed bench for frame_reader on an 8x2 frame with a 2-cycle SRAM model.
module tb_frame_reader;

  localparam int IMG_W      = 8;
  localparam int IMG_H      = 2;
  localparam int ADDR_W     = 18;
  localparam int FIFO_DEPTH = 4;
  localparam int NPIX       = IMG_W * IMG_H;
  localparam int NWORDS     = NPIX / 4;
  localparam logic [ADDR_W-1:0] BASE = 18'h100;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic              mem_rd_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_gnt;
  logic              mem_rd_valid;
  logic [15:0]       mem_rd_data;
  logic [3:0]        pixel_out;
  logic              out_ready;
  logic              out_stall;
  logic              sof, eol, eof, busy, done;

  always #5 clk = ~clk;

  frame_reader #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .mem_rd_req(mem_rd_req), .mem_addr(mem_addr), .mem_rd_gnt(mem_rd_gnt),
    .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
    .pixel_out(pixel_out), .out_ready(out_ready), .out_stall(out_stall),
    .sof(sof), .eol(eol), .eof(eof), .busy(busy), .done(done)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory contents: word k carries pixels 4k..4k+3, low nibble first.
  function automatic logic [15:0] word_of(input int k);
    logic [15:0] w;
    for (int i = 0; i < 4; i++) w[4*i +: 4] = 4'((4*k + i) % 16);
    return w;
  endfunction

  // ---------------- SRAM model: grant policy + 2-cycle return ----------------
  int gnt_delay_cfg = 0;
  bit inject_late   = 1'b0;
  int mcyc = 0;
  int held = 0;
  int due_q[$];
  int idx_q[$];
  int mk;

  always @(negedge clk) begin
    #1;
    mcyc++;
    mem_rd_valid = 1'b0;
    mem_rd_data  = '0;
    if (due_q.size() > 0 && due_q[0] == mcyc) begin
      void'(due_q.pop_front());
      mk = idx_q.pop_front();
      mem_rd_valid = 1'b1;
      mem_rd_data  = word_of(mk);
    end else if (inject_late) begin
      mem_rd_valid = 1'b1;
      mem_rd_data  = 16'hFFFF;
    end
    mem_rd_gnt = 1'b0;
    if (mem_rd_req) begin
      if (mem_addr == BASE && held < gnt_delay_cfg) begin
        held++;
      end else begin
        mem_rd_gnt = 1'b1;
        if (mem_addr == BASE) held = 0;
        due_q.push_back(mcyc + 2);
        idx_q.push_back(int'(mem_addr - BASE));
      end
    end
  end

  // ---------------- reference model and per-cycle checker ----------------
  int   m_n = 0;
  bit   m_busy = 1'b0;
  bit   m_done_exp = 1'b0;
  logic [ADDR_W-1:0] m_base = '0;
  bit   prev_rst = 1'b0;
  bit   prev_hold = 1'b0;
  logic [7:0] prev_out = '0;
  bit   xf, was_busy;
  int   ccyc = 0;
  int   frames_done = 0;
  int   done_pulses = 0;
  int   f_grants = 0, f_pix = 0, f_gnt_wait = 0, f_stall_cyc = 0;
  int   f_sof = 0, f_eol = 0, f_eof = 0;
  int   f_first_addr = -1, f_last_addr = -1, f_first_valid = -1, f_first_pix = -1;

  always @(negedge clk) begin
    #2;
    ccyc++;
    was_busy = m_busy;
    if (prev_rst)
      check("reset_outputs", {busy, done, out_ready, sof, eol, eof, mem_rd_req, pixel_out, mem_addr}, 0);
    check("busy", busy, m_busy);
    check("done", done, m_done_exp);
    if (!m_busy) begin
      check("idle_req", mem_rd_req, 0);
      check("idle_ready", out_ready, 0);
    end
    if (mem_rd_req) check("req_addr", mem_addr, m_base + f_grants);
    if (m_busy && f_grants >= NWORDS) check("req_after_last", mem_rd_req, 0);
    if (prev_hold && !prev_rst)
      check("stall_hold", {pixel_out, out_ready, sof, eol, eof}, prev_out);
    if (out_ready)
      check("pixel", {pixel_out, sof, eol, eof},
            {4'(m_n % 16), (m_n == 0), ((m_n % IMG_W) == IMG_W - 1), (m_n == NPIX - 1)});

    if (done) done_pulses++;
    xf        = out_ready && !out_stall && !rst;
    prev_hold = out_ready && out_stall;
    prev_out  = {pixel_out, out_ready, sof, eol, eof};
    if (mem_rd_valid && m_busy && f_first_valid < 0) f_first_valid = ccyc;
    if (out_ready && f_first_pix < 0) f_first_pix = ccyc;
    if (mem_rd_req && !mem_rd_gnt) f_gnt_wait++;
    if (mem_rd_req && mem_rd_gnt) begin
      if (f_grants == 0) f_first_addr = int'(mem_addr);
      f_last_addr = int'(mem_addr);
      f_grants++;
    end
    if (out_ready && out_stall) f_stall_cyc++;
    m_done_exp = 1'b0;
    if (xf) begin
      f_pix++;
      if (sof) f_sof++;
      if (eol) f_eol++;
      if (eof) f_eof++;
      if (m_n == NPIX - 1) begin
        m_done_exp = 1'b1;
        m_busy     = 1'b0;
        m_n        = 0;
        frames_done++;
      end else begin
        m_n++;
      end
    end
    if (!was_busy && start && !rst) begin
      m_busy = 1'b1;
      m_base = base_addr;
      f_grants = 0; f_pix = 0; f_gnt_wait = 0; f_stall_cyc = 0;
      f_sof = 0; f_eol = 0; f_eof = 0;
      f_first_addr = -1; f_last_addr = -1; f_first_valid = -1; f_first_pix = -1;
    end
    if (rst) begin
      m_busy     = 1'b0;
      m_n        = 0;
      m_done_exp = 1'b0;
    end
    prev_rst = rst;
  end

  // ---------------- stimulus helpers ----------------
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int i = 0;
    while (!done && i < 200) begin
      @(negedge clk);
      i++;
    end
    check({name, "_done_seen"}, done, 1);
  endtask

  task automatic wait_pixel(input int p, input string name);
    int i = 0;
    while (!(out_ready && m_n == p) && i < 200) begin
      @(negedge clk);
      i++;
    end
    check({name, "_pixel_reached"}, {out_ready, pixel_out}, {1'b1, 4'(p)});
  endtask

  int d0, fr0;

  initial begin
    rst = 1'b1; start = 1'b1; base_addr = BASE; out_stall = 1'b0;
    mem_rd_gnt = 1'b0; mem_rd_valid = 1'b0; mem_rd_data = '0;

    // Reset held with start asserted
    repeat (3) @(negedge clk);
    check("rst_outputs_zero", {busy, mem_rd_req, out_ready, done, sof, eol, eof, pixel_out}, 0);
    rst = 1'b0; start = 1'b0;
    repeat (2) @(negedge clk);

    // Basic frame
    d0 = done_pulses;
    pulse_start();
    check("busy_after_start", {busy, mem_rd_req, mem_addr}, {1'b1, 1'b1, 18'h100});
    wait_done("basic");
    repeat (3) @(negedge clk);
    check("basic_first_addr", f_first_addr, 32'h100);
    check("basic_last_addr", f_last_addr, 32'h103);
    check("basic_grants", f_grants, 4);
    check("basic_pixels", f_pix, 16);
    check("basic_sof_cnt", f_sof, 1);
    check("basic_eol_cnt", f_eol, 2);
    check("basic_eof_cnt", f_eof, 1);
    check("basic_latency", f_first_pix - f_first_valid, 2);
    check("basic_done_pulses", done_pulses - d0, 1);

    // Backpressure at pixel 5
    pulse_start();
    wait_pixel(5, "stall");
    out_stall = 1'b1;
    repeat (3) @(negedge clk);
    check("stall_pixel_held", {out_ready, pixel_out}, {1'b1, 4'd5});
    check("stall_no_req", mem_rd_req, 0);
    repeat (3) @(negedge clk);
    out_stall = 1'b0;
    wait_done("stall");
    repeat (2) @(negedge clk);
    check("stall_pixels", f_pix, 16);
    check("stall_cycles", f_stall_cyc, 6);
    check("stall_grants", f_grants, 4);

    // Grant withheld for 5 cycles on the first request
    gnt_delay_cfg = 5;
    pulse_start();
    wait_done("gntdly");
    gnt_delay_cfg = 0;
    repeat (2) @(negedge clk);
    check("gntdly_wait_cycles", f_gnt_wait, 5);
    check("gntdly_first_addr", f_first_addr, 32'h100);
    check("gntdly_latency", f_first_pix - f_first_valid, 2);
    check("gntdly_pixels", f_pix, 16);

    // Start ignored mid-frame, then accepted in the done cycle
    fr0 = frames_done;
    pulse_start();
    repeat (3) @(negedge clk);
    pulse_start();
    wait_done("restart1");
    pulse_start();
    check("restart_busy", {busy, mem_rd_req, mem_addr}, {1'b1, 1'b1, 18'h100});
    wait_done("restart2");
    repeat (2) @(negedge clk);
    check("restart_frames", frames_done - fr0, 2);
    check("restart_first_addr", f_first_addr, 32'h100);
    check("restart_pixels", f_pix, 16);

    // Abort by reset mid-frame, late return ignored, clean restart
    pulse_start();
    wait_pixel(6, "abort");
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    inject_late = 1'b1;
    @(negedge clk);
    inject_late = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_idle", {busy, out_ready, mem_rd_req, done, pixel_out}, 0);
    pulse_start();
    wait_done("abort_new");
    repeat (2) @(negedge clk);
    check("abort_new_pixels", f_pix, 16);
    check("abort_new_first_addr", f_first_addr, 32'h100);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
